// File: rtl/wb_syscon_seq.sv
// ---------------------------------------------------------------------------
// wb_syscon_seq
//
// Wishbone SYSCON sequencer. From the single system clock it derives a
// slow-domain tick (slow_en_o, one cycle high every DIV cycles) and uses that
// tick to sequence the resets of CHANNELS Wishbone sub-domains:
//   HOLD    : every rst_o bit high for RST_CYCLES ticks after reset.
//   RELEASE : rst_o bits cleared one per tick, channel 0 first.
//   RUN     : normal operation; each channel can be put back into reset by
//             software through req_rst_i and is released again after
//             RST_CYCLES ticks.
//
// Build option:
//   WBXBC_SYSCON_STAGGER_EN  defined   -> staggered release (RELEASE state).
//                            undefined -> one extra tick after HOLD releases
//                                         every channel at once.
//
// Parameters:
//   CHANNELS   number of reset domains (>= 1)
//   DIV        fast-to-slow clock ratio (>= 2)
//   RST_CYCLES reset hold length in slow ticks (>= 1)
//
// Ports:
//   clk_i       in   system clock, rising edge
//   sync_rst_i  in   synchronous active-high reset
//   req_rst_i   in   [CHANNELS] per-channel software reset request (level)
//   slow_en_o   out  slow tick, registered
//   rst_o       out  [CHANNELS] per-channel synchronous active-high reset
//   ready_o     out  high in RUN while no channel is held in reset
// ---------------------------------------------------------------------------
module wb_syscon_seq #(
  parameter int CHANNELS   = 4,
  parameter int DIV        = 4,
  parameter int RST_CYCLES = 8
) (
  input  logic                clk_i,
  input  logic                sync_rst_i,
  input  logic [CHANNELS-1:0] req_rst_i,
  output logic                slow_en_o,
  output logic [CHANNELS-1:0] rst_o,
  output logic                ready_o
);

  localparam int DIV_W = $clog2(DIV);
  localparam int CNT_W = $clog2(RST_CYCLES + 1);

  // slow_en_o is registered, so it is loaded one count early to line up
  // with the cycle where div_cnt reaches DIV-1.
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(DIV - 2);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);

`ifdef WBXBC_SYSCON_STAGGER_EN
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE_ALL,
    ST_RUN
  } state_t;
`endif

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [CNT_W-1:0]    tick_cnt;
  logic [CNT_W-1:0]    hold_cnt [CHANNELS];
  logic [CHANNELS-1:0] pend;
`ifdef WBXBC_SYSCON_STAGGER_EN
  logic [IDX_W-1:0]    idx;
`endif

  // Clock divider: free-running modulo-DIV count and the registered tick.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      div_cnt   <= '0;
      slow_en_o <= 1'b0;
    end else begin
      slow_en_o <= (div_cnt == DIV_PRE);
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Reset sequencer. All state advances only on slow ticks, except the
  // pending flags, which capture a request in any RUN cycle so a one-cycle
  // pulse between ticks is not lost.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state    <= ST_HOLD;
      tick_cnt <= '0;
      rst_o    <= '1;
      pend     <= '0;
`ifdef WBXBC_SYSCON_STAGGER_EN
      idx      <= '0;
`endif
      for (int n = 0; n < CHANNELS; n++) begin
        hold_cnt[n] <= '0;
      end
    end else begin
      case (state)
        ST_HOLD: begin
          if (slow_en_o) begin
            if (tick_cnt == CNT_LAST) begin
              tick_cnt <= '0;
`ifdef WBXBC_SYSCON_STAGGER_EN
              state    <= ST_RELEASE;
`else
              state    <= ST_RELEASE_ALL;
`endif
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end

`ifdef WBXBC_SYSCON_STAGGER_EN
        ST_RELEASE: begin
          if (slow_en_o) begin
            rst_o[idx] <= 1'b0;
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= ST_RUN;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
`else
        ST_RELEASE_ALL: begin
          if (slow_en_o) begin
            rst_o <= '0;
            state <= ST_RUN;
          end
        end
`endif

        ST_RUN: begin
          for (int n = 0; n < CHANNELS; n++) begin
            if (slow_en_o) begin
              // A request seen on the tick itself is honoured on that tick;
              // re-requesting while in reset restarts the hold.
              if (pend[n] || req_rst_i[n]) begin
                rst_o[n]    <= 1'b1;
                hold_cnt[n] <= '0;
                pend[n]     <= 1'b0;
              end else if (rst_o[n]) begin
                if (hold_cnt[n] == CNT_LAST) begin
                  rst_o[n]    <= 1'b0;
                  hold_cnt[n] <= '0;
                end else begin
                  hold_cnt[n] <= hold_cnt[n] + CNT_W'(1);
                end
              end
            end else if (req_rst_i[n]) begin
              pend[n] <= 1'b1;
            end
          end
        end

        default: begin
          state <= ST_HOLD;
        end
      endcase
    end
  end

  // Derived directly from registered state, so it moves on the same edge
  // as the last rst_o bit.
  assign ready_o = (state == ST_RUN) && !(|rst_o);

endmodule

// File: tb/tb_wb_syscon_seq.sv
// ---------------------------------------------------------------------------
// tb_wb_syscon_seq
//
// Self-checking bench for wb_syscon_seq. A cycle-level reference model,
// written in terms of cycle numbers since the last reset, predicts
// slow_en_o, rst_o and ready_o every cycle. Stimulus: a power-on run with
// all requests held high during the start-up sequence, a directed
// mid-operation reset, then a long randomized run with random requests and
// random reset pulses.
// ---------------------------------------------------------------------------
module tb_wb_syscon_seq;

  localparam int CHANNELS   = 4;
  localparam int DIV        = 4;
  localparam int RST_CYCLES = 8;
  localparam int HOLD_LEN   = RST_CYCLES * DIV;

`ifdef WBXBC_SYSCON_STAGGER_EN
  localparam bit STAGGER = 1'b1;
`else
  localparam bit STAGGER = 1'b0;
`endif

  localparam int RUN_START = STAGGER ? (RST_CYCLES + CHANNELS) * DIV
                                     : (RST_CYCLES + 1) * DIV;

  logic                clk = 1'b0;
  logic                sync_rst;
  logic [CHANNELS-1:0] req_rst;
  logic                slow_en;
  logic [CHANNELS-1:0] rst_v;
  logic                ready;

  always #5 clk = ~clk;

  wb_syscon_seq #(
    .CHANNELS   (CHANNELS),
    .DIV        (DIV),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk_i      (clk),
    .sync_rst_i (sync_rst),
    .req_rst_i  (req_rst),
    .slow_en_o  (slow_en),
    .rst_o      (rst_v),
    .ready_o    (ready)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: t is the cycle number since reset was last released.
  int t;
  bit model_pend [CHANNELS];
  int sw_start   [CHANNELS];
  int sw_end     [CHANNELS];

  // One comparison: count it and report any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h",
               tag, t, observed, expected);
    end
  endtask

  function automatic int po_release(input int n);
    return STAGGER ? (RST_CYCLES + 1 + n) * DIV : (RST_CYCLES + 1) * DIV;
  endfunction

  function automatic logic [CHANNELS-1:0] exp_rst();
    logic [CHANNELS-1:0] r;
    for (int n = 0; n < CHANNELS; n++) begin
      r[n] = (t < po_release(n)) || (t >= sw_start[n] && t < sw_end[n]);
    end
    return r;
  endfunction

  task automatic model_clear();
    t = 0;
    for (int n = 0; n < CHANNELS; n++) begin
      model_pend[n] = 1'b0;
      sw_start[n]   = 0;
      sw_end[n]     = 0;
    end
  endtask

  // Compare all outputs for the current cycle against the model.
  task automatic check_cycle();
    logic [CHANNELS-1:0] er;
    er = exp_rst();
    checkOutput("slow_en", 32'(slow_en), 32'((t % DIV) == (DIV - 1)));
    checkOutput("rst_o",   32'(rst_v),   32'(er));
    checkOutput("ready",   32'(ready),   32'((t >= RUN_START) && (er == '0)));
  endtask

  // Drive the inputs for the current cycle and advance the model across the
  // edge that ends it.
  task automatic applyStimulus(input bit rst_in, input logic [CHANNELS-1:0] req_in);
    sync_rst = rst_in;
    req_rst  = req_in;
    if (rst_in) begin
      model_clear();
    end else begin
      if (t >= RUN_START) begin
        for (int n = 0; n < CHANNELS; n++) begin
          if ((t % DIV) == (DIV - 1)) begin
            if (model_pend[n] || req_in[n]) begin
              sw_start[n]   = t + 1;
              sw_end[n]     = t + 1 + HOLD_LEN;
              model_pend[n] = 1'b0;
            end
          end else if (req_in[n]) begin
            model_pend[n] = 1'b1;
          end
        end
      end
      t++;
    end
  endtask

  // One full bench cycle: wait for the edge, check, then drive.
  task automatic step(input bit rst_in, input logic [CHANNELS-1:0] req_in);
    @(posedge clk);
    #1;
    check_cycle();
    applyStimulus(rst_in, req_in);
  endtask

  initial begin
    logic [CHANNELS-1:0] req_v;
    int rst_left;

    sync_rst = 1'b1;
    req_rst  = '0;
    model_clear();

    // Hold reset for a few cycles; first check covers the reset state.
    repeat (3) step(1'b1, '0);

    // Power-on run with every request held high until RUN begins.
    $display("[TB] power-on sequence, stagger=%0d", STAGGER);
    for (int i = 0; i < 200; i++) begin
      step(1'b0, (t < RUN_START) ? '1 : '0);
    end

    // Directed software requests: channel 2 alone, then 1 and 3 together
    // with an extending re-request on channel 1.
    $display("[TB] directed software resets");
    step(1'b1, '0);
    for (int i = 0; i < 200; i++) begin
      req_v = '0;
      if (t == 60) req_v = 4'b0100;
      if (t == 140) req_v = 4'b1010;
      if (t == 160) req_v = 4'b0010;
      step(1'b0, req_v);
    end

    // Mid-operation reset at cycle 42 for two cycles.
    $display("[TB] mid-operation reset");
    step(1'b1, '0);
    while (t < 42) step(1'b0, '0);
    step(1'b1, '0);
    step(1'b1, '0);
    for (int i = 0; i < 120; i++) step(1'b0, '0);

    // Randomized run: sparse random requests and occasional reset pulses.
    $display("[TB] randomized run");
    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < CHANNELS; n++) begin
        req_v[n] = ($urandom_range(0, 31) == 0);
      end
      if (rst_left == 0 && $urandom_range(0, 499) == 0) begin
        rst_left = $urandom_range(1, 3);
      end
      if (rst_left > 0) begin
        rst_left--;
        step(1'b1, req_v);
      end else begin
        step(1'b0, req_v);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
